// File: rtl/lstm.sv
// lstm - single-cell int8 LSTM accelerator for syscall-sequence inference.
//
// Weights (512 B), biases (32 B) and the initial context (c, h) are
// streamed in byte-serially while idle. Each accepted input vector x runs
// one LSTM time step. The step is a 512-entry multiply-accumulate sweep
// followed by an 8-element cell/hidden update. oLstm_done reasserts 521
// edges after the accepting edge, together with the new c and h.
//
// Numbers are signed Q4.4 (1.0 = 16).
//
// Optional build macro:
//   LSTM_SAT_EN : narrowing to 8 bits saturates to [-128,127].
//                 When it is not defined, narrowing keeps the low byte.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   iInit_valid/data/type  parameter byte stream
//                          (type 0 weight, 1 bias, 2 context, 7 idle)
//   iLoad_valid            load c/h from iBr_Ct_load/iBr_Ht_load [63:0]
//   iNext_valid, iType     start one step (iType 0 only), x taken from iData[63:0]
//   oLstm_done             idle and ready
//   oBr_Ct, oBr_Ht         tied to zero
//   oSys_Ct, oSys_Ht       current c and h, byte j at [8j+7:8j]
module lstm #(
    parameter int X_SIZE = 8,
    parameter int H_SIZE = 8,
    parameter int FRAC   = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         iInit_valid,
    input  logic [7:0]   iInit_data,
    input  logic [2:0]   iInit_type,
    input  logic         iLoad_valid,
    input  logic [511:0] iBr_Ct_load,
    input  logic [511:0] iBr_Ht_load,
    input  logic         iNext_valid,
    input  logic         iType,
    input  logic [511:0] iData,
    output logic         oLstm_done,
    output logic [511:0] oBr_Ct,
    output logic [511:0] oBr_Ht,
    output logic [63:0]  oSys_Ct,
    output logic [63:0]  oSys_Ht
);
    localparam int COLS  = X_SIZE + H_SIZE;
    localparam int ROWS  = 4 * H_SIZE;
    localparam int N_W   = ROWS * COLS;
    localparam int WA    = $clog2(N_W);
    localparam int CW    = WA + 1;
    localparam int CB    = $clog2(COLS);
    localparam int RB    = $clog2(ROWS);
    localparam int HB    = $clog2(H_SIZE);
    localparam int XB    = $clog2(X_SIZE);
    localparam logic [CW-1:0] N_W_C   = CW'(N_W);
    localparam logic [CW-1:0] N_B_C   = CW'(ROWS);
    localparam logic [CW-1:0] N_CTX_C = CW'(2 * H_SIZE);
    localparam logic [CW-1:0] H_C     = CW'(H_SIZE);

    typedef enum logic [1:0] {IDLE, MAC, UPDATE} state_t;

    state_t state, state_next;

    logic signed [7:0] weight [N_W];
    logic signed [7:0] bias   [ROWS];
    logic signed [7:0] c_reg  [H_SIZE];
    logic signed [7:0] h_reg  [H_SIZE];
    logic signed [7:0] x_reg  [X_SIZE];
    logic signed [7:0] act    [ROWS];
    logic signed [7:0] c_new  [H_SIZE];
    logic signed [7:0] h_new  [H_SIZE];

    logic [CW-1:0]      ptr, wr_addr;
    logic [2:0]         last_type;
    logic [CW-1:0]      issue_cnt;
    logic [CB-1:0]      issue_col, prod_col;
    logic [RB-1:0]      issue_row, prod_row;
    logic signed [15:0] prod_q, prod_next;
    logic               prod_v;
    logic signed [23:0] acc, acc_sum, bias_ext, pre_sum;
    logic [HB-1:0]      upd_idx, issue_h_idx;
    logic signed [7:0]  operand, p, act_val, c_val, h_val;
    logic [RB-1:0]      i_idx, f_idx, g_idx, o_idx;
    logic signed [15:0] fc, ig, oc;
    logic signed [23:0] mix, oc_ext;
    logic               idle, step_go, last_upd;
    logic               unused_bits;

    function automatic logic signed [7:0] narrow(input logic signed [23:0] v);
`ifdef LSTM_SAT_EN
        if (v > 24'sd127)
            return 8'sd127;
        else if (v < -24'sd128)
            return -8'sd128;
        else
            return v[7:0];
`else
        return v[7:0];
`endif
    endfunction

    function automatic logic signed [7:0] clamp16(input logic signed [7:0] v);
        if (v > 8'sd16)
            return 8'sd16;
        else if (v < -8'sd16)
            return -8'sd16;
        else
            return v;
    endfunction

    // Piecewise-linear sigmoid: (p >>> 2) + 8, clamped to [0, 16].
    // One spare sign bit keeps the +8 from overflowing.
    function automatic logic signed [7:0] sigm(input logic signed [7:0] v);
        logic signed [8:0] s;
        s = {v[7], v[7], v[7], v[7:2]};
        s = s + 9'sd8;
        if (s < 9'sd0)
            return 8'sd0;
        else if (s > 9'sd16)
            return 8'sd16;
        else
            return s[7:0];
    endfunction

    assign idle     = (state == IDLE);
    assign step_go  = idle && iNext_valid && !iType;
    assign last_upd = (upd_idx == HB'(H_SIZE - 1));
    // The first byte after a type change lands at address 0.
    assign wr_addr  = (iInit_type != last_type) ? '0 : ptr;

    assign oLstm_done  = idle;
    assign oBr_Ct      = '0;
    assign oBr_Ht      = '0;
    assign unused_bits = ^{iBr_Ct_load[511:8*H_SIZE], iBr_Ht_load[511:8*H_SIZE],
                           iData[511:8*X_SIZE]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (step_go) state_next = MAC;
            MAC:     if (issue_cnt == N_W_C) state_next = UPDATE;
            UPDATE:  if (last_upd) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath arithmetic. The multiplier output is registered, so
    // accumulation runs one cycle behind issue.
    always_comb begin
        issue_h_idx = HB'(issue_col - CB'(X_SIZE));
        if (issue_col < CB'(X_SIZE))
            operand = x_reg[issue_col[XB-1:0]];
        else
            operand = h_reg[issue_h_idx];
        prod_next = weight[issue_cnt[WA-1:0]] * operand;

        acc_sum  = acc + {{8{prod_q[15]}}, prod_q};
        bias_ext = {{(24-8-FRAC){bias[prod_row][7]}}, bias[prod_row], {FRAC{1'b0}}};
        pre_sum  = acc_sum + bias_ext;
        p        = narrow(pre_sum >>> FRAC);
        if (prod_row[RB-1:HB] == 2'd2)
            act_val = clamp16(p);
        else
            act_val = sigm(p);

        i_idx  = RB'(upd_idx);
        f_idx  = i_idx + RB'(H_SIZE);
        g_idx  = i_idx + RB'(2 * H_SIZE);
        o_idx  = i_idx + RB'(3 * H_SIZE);
        fc     = act[f_idx] * c_reg[upd_idx];
        ig     = act[i_idx] * act[g_idx];
        mix    = {{8{fc[15]}}, fc} + {{8{ig[15]}}, ig};
        c_val  = narrow(mix >>> FRAC);
        oc     = act[o_idx] * clamp16(c_val);
        oc_ext = {{8{oc[15]}}, oc};
        h_val  = narrow(oc_ext >>> FRAC);
    end

    // Weight and bias memories, written from the byte stream while idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < N_W; k++) weight[k] <= '0;
            for (int k = 0; k < ROWS; k++) bias[k] <= '0;
            ptr       <= '0;
            last_type <= 3'd7;
        end else if (idle && iInit_valid && !iLoad_valid) begin
            last_type <= iInit_type;
            if (wr_addr != N_W_C)
                ptr <= wr_addr + CW'(1);
            if (iInit_type == 3'd0 && wr_addr < N_W_C)
                weight[wr_addr[WA-1:0]] <= iInit_data;
            if (iInit_type == 3'd1 && wr_addr < N_B_C)
                bias[wr_addr[RB-1:0]] <= iInit_data;
        end else begin
            ptr <= '0;
        end
    end

    // Context: direct load, streamed load, and end-of-step commit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < H_SIZE; k++) begin
                c_reg[k] <= '0;
                h_reg[k] <= '0;
            end
        end else if (idle) begin
            if (iLoad_valid) begin
                for (int k = 0; k < H_SIZE; k++) begin
                    c_reg[k] <= iBr_Ct_load[8*k +: 8];
                    h_reg[k] <= iBr_Ht_load[8*k +: 8];
                end
            end else if (iInit_valid && iInit_type == 3'd2 && wr_addr < N_CTX_C) begin
                if (wr_addr < H_C)
                    c_reg[wr_addr[HB-1:0]] <= iInit_data;
                else
                    h_reg[wr_addr[HB-1:0]] <= iInit_data;
            end
        end else if (state == UPDATE && last_upd) begin
            for (int k = 0; k < H_SIZE - 1; k++) begin
                c_reg[k] <= c_new[k];
                h_reg[k] <= h_new[k];
            end
            c_reg[H_SIZE-1] <= c_val;
            h_reg[H_SIZE-1] <= h_val;
        end
    end

    // Step sequencing: MAC sweep (gate, row, col) then element-wise update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < X_SIZE; k++) x_reg[k] <= '0;
            for (int k = 0; k < ROWS; k++) act[k] <= '0;
            for (int k = 0; k < H_SIZE; k++) begin
                c_new[k] <= '0;
                h_new[k] <= '0;
            end
            issue_cnt <= '0;
            issue_col <= '0;
            issue_row <= '0;
            prod_q    <= '0;
            prod_v    <= 1'b0;
            prod_col  <= '0;
            prod_row  <= '0;
            acc       <= '0;
            upd_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (step_go) begin
                        for (int k = 0; k < X_SIZE; k++) x_reg[k] <= iData[8*k +: 8];
                        issue_cnt <= '0;
                        issue_col <= '0;
                        issue_row <= '0;
                        prod_v    <= 1'b0;
                        acc       <= '0;
                        upd_idx   <= '0;
                    end
                end
                MAC: begin
                    if (issue_cnt != N_W_C) begin
                        prod_q    <= prod_next;
                        prod_v    <= 1'b1;
                        prod_col  <= issue_col;
                        prod_row  <= issue_row;
                        issue_cnt <= issue_cnt + CW'(1);
                        if (issue_col == CB'(COLS - 1)) begin
                            issue_col <= '0;
                            issue_row <= issue_row + RB'(1);
                        end else begin
                            issue_col <= issue_col + CB'(1);
                        end
                    end else begin
                        prod_v <= 1'b0;
                    end
                    if (prod_v) begin
                        if (prod_col == CB'(COLS - 1)) begin
                            act[prod_row] <= act_val;
                            acc           <= '0;
                        end else begin
                            acc <= acc_sum;
                        end
                    end
                end
                UPDATE: begin
                    c_new[upd_idx] <= c_val;
                    h_new[upd_idx] <= h_val;
                    upd_idx        <= upd_idx + HB'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        oSys_Ct = '0;
        oSys_Ht = '0;
        for (int k = 0; k < H_SIZE; k++) begin
            oSys_Ct[8*k +: 8] = c_reg[k];
            oSys_Ht[8*k +: 8] = h_reg[k];
        end
    end

endmodule

// File: tb/tb_lstm.sv
// tb_lstm - directed self-checking bench for the lstm accelerator.
// Every scenario task drives its own stimulus and checks results against
// hand-computed constants. The weight-overflow expectation follows the
// LSTM_SAT_EN build macro.
module tb_lstm;
    logic         clk = 1'b0;
    logic         resetn;
    logic         iInit_valid;
    logic [7:0]   iInit_data;
    logic [2:0]   iInit_type;
    logic         iLoad_valid;
    logic [511:0] iBr_Ct_load;
    logic [511:0] iBr_Ht_load;
    logic         iNext_valid;
    logic         iType;
    logic [511:0] iData;
    logic         oLstm_done;
    logic [511:0] oBr_Ct;
    logic [511:0] oBr_Ht;
    logic [63:0]  oSys_Ct;
    logic [63:0]  oSys_Ht;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] stream_buf [512];

    lstm dut (
        .clk         (clk),
        .resetn      (resetn),
        .iInit_valid (iInit_valid),
        .iInit_data  (iInit_data),
        .iInit_type  (iInit_type),
        .iLoad_valid (iLoad_valid),
        .iBr_Ct_load (iBr_Ct_load),
        .iBr_Ht_load (iBr_Ht_load),
        .iNext_valid (iNext_valid),
        .iType       (iType),
        .iData       (iData),
        .oLstm_done  (oLstm_done),
        .oBr_Ct      (oBr_Ct),
        .oBr_Ht      (oBr_Ht),
        .oSys_Ct     (oSys_Ct),
        .oSys_Ht     (oSys_Ht)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        iInit_valid = 1'b0;
        iInit_data  = 8'h00;
        iInit_type  = 3'd7;
        iLoad_valid = 1'b0;
        iBr_Ct_load = '0;
        iBr_Ht_load = '0;
        iNext_valid = 1'b0;
        iType       = 1'b0;
        iData       = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic clear_buf();
        for (int k = 0; k < 512; k++) stream_buf[k] = 8'h00;
    endtask

    task automatic stream(input logic [2:0] typ, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            iInit_valid = 1'b1;
            iInit_type  = typ;
            iInit_data  = stream_buf[k];
        end
        @(negedge clk);
        iInit_valid = 1'b0;
        iInit_type  = 3'd7;
    endtask

    // Starts one step and counts edges until done returns (bounded).
    task automatic run_step(input logic [63:0] x, output logic dropped, output int lat);
        @(negedge clk);
        iData       = '0;
        iData[63:0] = x;
        iType       = 1'b0;
        iNext_valid = 1'b1;
        @(posedge clk);
        #1;
        iNext_valid = 1'b0;
        dropped = !oLstm_done;
        lat = 0;
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk);
            #1;
            if (oLstm_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        n_checks++;
        if (oLstm_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_done: got %b expected 1", oLstm_done);
        end
        n_checks++;
        if (oSys_Ht !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_ht: got %h expected 0", oSys_Ht);
        end
        n_checks++;
        if (oSys_Ct !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_ct: got %h expected 0", oSys_Ct);
        end
        n_checks++;
        if ((oBr_Ct | oBr_Ht) !== 512'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_br: got nonzero expected 0");
        end
    endtask

    task automatic test_zero_step();
        logic dropped;
        int lat;
        $display("[TB] test_zero_step");
        run_step(64'hF1E2D3C4B5A69788, dropped, lat);
        n_checks++;
        if (dropped !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL zero_done_drop: got %b expected 1", dropped);
        end
        n_checks++;
        if (lat !== 521) begin
            n_fail++;
            $display("[TB] FAIL zero_latency: got %0d expected 521", lat);
        end
        n_checks++;
        if (oSys_Ht !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL zero_ht: got %h expected 0", oSys_Ht);
        end
        n_checks++;
        if (oSys_Ct !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL zero_ct: got %h expected 0", oSys_Ct);
        end
    endtask

    task automatic test_bias_g();
        logic dropped;
        int lat;
        $display("[TB] test_bias_g");
        apply_reset();
        clear_buf();
        for (int k = 16; k < 24; k++) stream_buf[k] = 8'd16;
        stream(3'd1, 32);
        run_step(64'h0102030405060708, dropped, lat);
        n_checks++;
        if (lat !== 521) begin
            n_fail++;
            $display("[TB] FAIL bias_latency1: got %0d expected 521", lat);
        end
        n_checks++;
        if (oSys_Ct !== 64'h0808080808080808) begin
            n_fail++;
            $display("[TB] FAIL bias_ct1: got %h expected 0808080808080808", oSys_Ct);
        end
        n_checks++;
        if (oSys_Ht !== 64'h0404040404040404) begin
            n_fail++;
            $display("[TB] FAIL bias_ht1: got %h expected 0404040404040404", oSys_Ht);
        end
        run_step(64'h0, dropped, lat);
        n_checks++;
        if (lat !== 521) begin
            n_fail++;
            $display("[TB] FAIL bias_latency2: got %0d expected 521", lat);
        end
        n_checks++;
        if (oSys_Ct !== 64'h0C0C0C0C0C0C0C0C) begin
            n_fail++;
            $display("[TB] FAIL bias_ct2: got %h expected 0C0C0C0C0C0C0C0C", oSys_Ct);
        end
        n_checks++;
        if (oSys_Ht !== 64'h0606060606060606) begin
            n_fail++;
            $display("[TB] FAIL bias_ht2: got %h expected 0606060606060606", oSys_Ht);
        end
    endtask

    task automatic test_weight_overflow();
        logic dropped;
        int lat;
        logic [63:0] exp_ct, exp_ht;
`ifdef LSTM_SAT_EN
        exp_ct = 64'h08;
        exp_ht = 64'h04;
`else
        exp_ct = 64'hF8;
        exp_ht = 64'hFC;
`endif
        $display("[TB] test_weight_overflow");
        apply_reset();
        clear_buf();
        stream_buf[256] = 8'd127;
        stream(3'd0, 257);
        run_step(64'h7F, dropped, lat);
        n_checks++;
        if (lat !== 521) begin
            n_fail++;
            $display("[TB] FAIL weight_latency: got %0d expected 521", lat);
        end
        n_checks++;
        if (oSys_Ct !== exp_ct) begin
            n_fail++;
            $display("[TB] FAIL weight_ct: got %h expected %h", oSys_Ct, exp_ct);
        end
        n_checks++;
        if (oSys_Ht !== exp_ht) begin
            n_fail++;
            $display("[TB] FAIL weight_ht: got %h expected %h", oSys_Ht, exp_ht);
        end
    endtask

    task automatic test_context();
        $display("[TB] test_context");
        apply_reset();
        for (int k = 0; k < 16; k++) stream_buf[k] = 8'(k + 1);
        stream(3'd2, 16);
        n_checks++;
        if (oSys_Ct !== 64'h0807060504030201) begin
            n_fail++;
            $display("[TB] FAIL ctx_ct: got %h expected 0807060504030201", oSys_Ct);
        end
        n_checks++;
        if (oSys_Ht !== 64'h100F0E0D0C0B0A09) begin
            n_fail++;
            $display("[TB] FAIL ctx_ht: got %h expected 100F0E0D0C0B0A09", oSys_Ht);
        end
        // Two bytes beyond the last address must be dropped.
        for (int k = 0; k < 18; k++) stream_buf[k] = 8'(8'h21 + k);
        stream(3'd2, 18);
        n_checks++;
        if (oSys_Ct !== 64'h2827262524232221) begin
            n_fail++;
            $display("[TB] FAIL ctx_over_ct: got %h expected 2827262524232221", oSys_Ct);
        end
        n_checks++;
        if (oSys_Ht !== 64'h302F2E2D2C2B2A29) begin
            n_fail++;
            $display("[TB] FAIL ctx_over_ht: got %h expected 302F2E2D2C2B2A29", oSys_Ht);
        end
        for (int k = 0; k < 4; k++) stream_buf[k] = 8'hAA;
        stream(3'd7, 4);
        n_checks++;
        if (oSys_Ct !== 64'h2827262524232221) begin
            n_fail++;
            $display("[TB] FAIL ctx_idle_type: got %h expected 2827262524232221", oSys_Ct);
        end
    endtask

    task automatic test_load();
        $display("[TB] test_load");
        apply_reset();
        @(negedge clk);
        iLoad_valid = 1'b1;
        iBr_Ct_load = {448'hDEAD, 64'h8877665544332211};
        iBr_Ht_load = {448'hBEEF, 64'h0123456789ABCDEF};
        iInit_valid = 1'b1;
        iInit_type  = 3'd2;
        iInit_data  = 8'hEE;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (oSys_Ct !== 64'h8877665544332211) begin
            n_fail++;
            $display("[TB] FAIL load_ct: got %h expected 8877665544332211", oSys_Ct);
        end
        n_checks++;
        if (oSys_Ht !== 64'h0123456789ABCDEF) begin
            n_fail++;
            $display("[TB] FAIL load_ht: got %h expected 0123456789ABCDEF", oSys_Ht);
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        logic stayed;
        $display("[TB] test_busy_ignore");
        apply_reset();
        @(negedge clk);
        iLoad_valid = 1'b1;
        iBr_Ct_load[63:0] = 64'h1010101010101010;
        iBr_Ht_load[63:0] = 64'h3333333333333333;
        @(negedge clk);
        idle_inputs();
        iNext_valid = 1'b1;
        @(posedge clk);
        #1;
        iNext_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 600; n++) begin
            @(posedge clk);
            #1;
            if (n == 100) begin
                iNext_valid = 1'b1;
                iInit_valid = 1'b1;
                iInit_type  = 3'd2;
                iInit_data  = 8'h55;
                iLoad_valid = 1'b1;
                iBr_Ct_load = '1;
                iBr_Ht_load = '1;
            end else if (n == 101) begin
                idle_inputs();
            end
            if (oLstm_done) begin
                lat = n;
                break;
            end
        end
        n_checks++;
        if (lat !== 521) begin
            n_fail++;
            $display("[TB] FAIL busy_latency: got %0d expected 521", lat);
        end
        n_checks++;
        if (oSys_Ct !== 64'h0808080808080808) begin
            n_fail++;
            $display("[TB] FAIL busy_ct: got %h expected 0808080808080808", oSys_Ct);
        end
        n_checks++;
        if (oSys_Ht !== 64'h0404040404040404) begin
            n_fail++;
            $display("[TB] FAIL busy_ht: got %h expected 0404040404040404", oSys_Ht);
        end
        stayed = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            stayed = stayed & oLstm_done;
        end
        n_checks++;
        if (stayed !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL busy_no_second_step: got %b expected 1", stayed);
        end
    endtask

    task automatic test_abort();
        $display("[TB] test_abort");
        @(negedge clk);
        iLoad_valid = 1'b1;
        iBr_Ct_load[63:0] = 64'h1111111111111111;
        iBr_Ht_load[63:0] = 64'h2222222222222222;
        @(negedge clk);
        idle_inputs();
        iNext_valid = 1'b1;
        @(negedge clk);
        iNext_valid = 1'b0;
        repeat (50) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (oLstm_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL abort_done: got %b expected 1", oLstm_done);
        end
        n_checks++;
        if (oSys_Ct !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL abort_ct: got %h expected 0", oSys_Ct);
        end
        n_checks++;
        if (oSys_Ht !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL abort_ht: got %h expected 0", oSys_Ht);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        clear_buf();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        test_reset();
        test_zero_step();
        test_bias_g();
        test_weight_overflow();
        test_context();
        test_load();
        test_busy_ignore();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
